// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle ALU with iterative multiply/divide and valid/ready handshake
//
// Purpose: single-cycle logic/arith ops (NAND, OR, ADD, SUB, SLT, SLL, MOVE)
// and iterative unsigned MUL/MULHU (shift-add) and DIVU/REMU (restoring
// divide), one request in flight, results held until the consumer takes them.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  request handshake (in_ready high only in IDLE)
//   a, b, shamt         operands and shift amount, captured on acceptance
//   alu_control         4-bit operation select
//   out_valid, out_ready result handshake
//   alu_out, zout       registered result and zero flag
//   ovf, dz             registered signed-overflow (ADD/SUB) and divide-by-zero flags
module alu_multicycle #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [3:0]         alu_control,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   alu_out,
  output logic               zout,
  output logic               ovf,
  output logic               dz
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;     // low bits of an iterative code: [1]=divide, [0]=upper half
  logic [WIDTH-1:0] acc_hi;   // MUL: running high product; DIV: partial remainder
  logic [WIDTH-1:0] acc_lo;   // MUL: multiplier shifting out / low product; DIV: dividend -> quotient

  // Single-cycle datapath, evaluated on the live inputs at acceptance
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [31:0]      shamt_ext;
  logic             is_iter;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;

  assign add_res   = a + b;
  assign sub_res   = a - b;
  assign shamt_ext = 32'(shamt);
  assign is_iter   = (alu_control[3:2] == 2'b10);

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (alu_control)
      4'b0000: sc_res = ~(a & b);
      4'b0001: sc_res = a | b;
      4'b0010: begin
        sc_res = add_res;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0110: begin
        sc_res = sub_res;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0111: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b0100: sc_res = (shamt_ext >= 32'(WIDTH)) ? '0 : (a << shamt);
      4'b0101: sc_res = a;
      default: sc_res = '0;
    endcase
  end

  // One iteration step of the shared multiply/divide datapath
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic [WIDTH-1:0] fin_res;

  assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? a_q : '0)};
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  // Only used when div_shift >= b, where the true difference is below 2^WIDTH
  assign div_diff  = div_shift[WIDTH-1:0] - b_q;

  always_comb begin
    nxt_hi = mul_sum[WIDTH:1];
    nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (op_q[1]) begin
      // b==0 always "fits": quotient fills with ones and the remainder
      // ends up as the shifted-in dividend, matching the div-by-zero contract
      nxt_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], div_ge};
    end
  end

  assign fin_res = op_q[0] ? nxt_hi : nxt_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      alu_out   <= '0;
      zout      <= 1'b0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= alu_control[1:0];
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= alu_control[1] ? a : b;
            in_ready <= 1'b0;
            if (is_iter) begin
              state <= BUSY;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              alu_out   <= sc_res;
              zout      <= (sc_res == '0);
              ovf       <= sc_ovf;
              dz        <= 1'b0;
            end
          end
        end
        BUSY: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + CNT_W'(1);
          // The last step's result goes straight to the output registers
          if (cnt == LAST_STEP) begin
            state     <= DONE;
            out_valid <= 1'b1;
            alu_out   <= fin_res;
            zout      <= (fin_res == '0);
            ovf       <= 1'b0;
            dz        <= op_q[1] && (b_q == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard testbench for alu_multicycle (WIDTH=32)
module tb_alu_multicycle;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [5:0]   shamt;
  logic [3:0]   alu_control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_out;
  logic         zout;
  logic         ovf;
  logic         dz;

  alu_multicycle #(.WIDTH(W), .SHAMT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .shamt(shamt), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .zout(zout), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        v;
    logic        d;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib,
                                 input logic [5:0] ish, input logic [3:0] op);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb_, s;
    e.res = '0; e.v = 1'b0; e.d = 1'b0;
    sa  = longint'($signed(ia));
    sb_ = longint'($signed(ib));
    p   = {32'b0, ia} * {32'b0, ib};
    case (op)
      4'd0:  e.res = ~(ia & ib);
      4'd1:  e.res = ia | ib;
      4'd2:  begin e.res = ia + ib; s = sa + sb_; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd6:  begin e.res = ia - ib; s = sa - sb_; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd7:  e.res = (ia < ib) ? 32'd1 : 32'd0;
      4'd4:  e.res = (ish >= 6'd32) ? 32'd0 : (ia << ish);
      4'd5:  e.res = ia;
      4'd8:  e.res = p[31:0];
      4'd9:  e.res = p[63:32];
      4'd10: begin e.res = (ib == 0) ? 32'hFFFF_FFFF : ia / ib; e.d = (ib == 0); end
      4'd11: begin e.res = (ib == 0) ? ia : ia % ib; e.d = (ib == 0); end
      default: e.res = '0;
    endcase
    e.z   = (e.res == 0);
    e.lat = (op >= 4'd8 && op <= 4'd11) ? 33 : 1;
    return e;
  endfunction

  // Drive one request, scramble inputs after acceptance, wait for the result,
  // compare against the scoreboard, then complete the output handshake.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        input logic [5:0] ish, input logic [3:0] op, input string tag);
    int   lat;
    exp_t e;
    @(negedge clk);
    a = ia; b = ib; shamt = ish; alu_control = op; in_valid = 1'b1; out_ready = 1'b0;
    check_eq({tag, "/in_ready"}, in_ready, 1);
    @(posedge clk);
    sb.push_back(model(ia, ib, ish, op));
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; shamt = 6'($urandom); alu_control = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) check_eq({tag, "/timeout"}, 0, 1);
    e = sb.pop_front();
    check_eq({tag, "/res"}, alu_out, e.res);
    check_eq({tag, "/zout"}, zout, e.z);
    check_eq({tag, "/ovf"}, ovf, e.v);
    check_eq({tag, "/dz"}, dz, e.d);
    check_eq({tag, "/lat"}, lat, e.lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "/ov_drop"}, out_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    logic [31:0] held;
    logic        saw_valid;
    logic [3:0]  ops [14];
    logic [31:0] ra, rb;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; shamt = '0; alu_control = '0;
    #12;
    check_eq("rst/in_ready", in_ready, 1);
    check_eq("rst/out_valid", out_valid, 0);
    check_eq("rst/alu_out", alu_out, 0);
    check_eq("rst/flags", {zout, ovf, dz}, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op(32'h7FFF_FFFF, 32'd1, 6'd0, 4'b0010, "add_ovf");
    run_op(32'h8000_0000, 32'd1, 6'd0, 4'b0110, "sub_ovf");
    run_op(32'd5, 32'd5, 6'd0, 4'b0110, "sub_zero");
    run_op(32'hF0F0_FFFF, 32'h0FF0_FFFF, 6'd0, 4'b0000, "nand");
    run_op(32'h1200_0034, 32'h0050_6000, 6'd0, 4'b0001, "or");
    run_op(32'd3, 32'hFFFF_FFFF, 6'd0, 4'b0111, "slt_lt");
    run_op(32'hFFFF_FFFF, 32'd3, 6'd0, 4'b0111, "slt_ge");
    run_op(32'hDEAD_BEEF, 32'd0, 6'd0, 4'b0101, "move");
    run_op(32'd1, 32'd0, 6'd31, 4'b0100, "sll31");
    run_op(32'd1, 32'd0, 6'd32, 4'b0100, "sll32");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd0, 4'b0011, "undef3");
    run_op(32'h0001_0000, 32'h0001_0000, 6'd0, 4'b1000, "mul");
    run_op(32'h0001_0000, 32'h0001_0000, 6'd0, 4'b1001, "mulhu");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd0, 4'b1001, "mulhu_max");
    run_op(32'd100, 32'd7, 6'd0, 4'b1010, "divu");
    run_op(32'd100, 32'd7, 6'd0, 4'b1011, "remu");
    run_op(32'd5, 32'd0, 6'd0, 4'b1010, "divu_dz");
    run_op(32'd5, 32'd0, 6'd0, 4'b1011, "remu_dz");
    run_op(32'hFFFF_FFFF, 32'd1, 6'd0, 4'b1010, "divu_by1");

    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd3, 4'd12, 4'd15};
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 28));
      run_op(ra, rb, 6'($urandom_range(0, 40)), ops[$urandom_range(0, 13)], "rand");
    end

    // Back-pressure: hold the result with a new request waiting on the inputs
    @(negedge clk);
    a = 32'd3; b = 32'd4; shamt = '0; alu_control = 4'b0010; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    sb.push_back(model(32'd3, 32'd4, 6'd0, 4'b0010));
    #1;
    a = 32'h0000_00F0; b = 32'h0000_000F; alu_control = 4'b0001;
    check_eq("stall/ov", out_valid, 1);
    e = sb.pop_front();
    held = alu_out;
    check_eq("stall/res", held, e.res);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("stall/hold_res", alu_out, e.res);
      check_eq("stall/hold_zout", zout, e.z);
      check_eq("stall/hold_ov", out_valid, 1);
      check_eq("stall/in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("stall/hs_ov", out_valid, 0);
    check_eq("stall/hs_in_ready", in_ready, 1);
    @(posedge clk);
    sb.push_back(model(32'h0000_00F0, 32'h0000_000F, 6'd0, 4'b0001));
    #1;
    in_valid = 1'b0;
    check_eq("stall/next_ov", out_valid, 1);
    e = sb.pop_front();
    check_eq("stall/next_res", alu_out, e.res);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of a MUL
    @(negedge clk);
    a = 32'h0001_0000; b = 32'h0001_0000; alu_control = 4'b1000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_busy/in_ready", in_ready, 1);
    check_eq("rst_busy/out_valid", out_valid, 0);
    check_eq("rst_busy/alu_out", alu_out, 0);
    check_eq("rst_busy/flags", {zout, ovf, dz}, 0);
    @(negedge clk); rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check_eq("rst_busy/no_stale", saw_valid, 0);
    run_op(32'd100, 32'd7, 6'd0, 4'b1011, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand and result width (legal values 8..64).
REQ-002 SHALL have parameter SHAMT_W, default 6, meaning the shift-amount width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  request valid.
REQ-007 in_ready  out  1  block can accept a request.
REQ-008 a  in  WIDTH  source 1 (rs).
REQ-009 b  in  WIDTH  source 2 (rt or immediate).
REQ-010 shamt  in  SHAMT_W  shift amount.
REQ-011 alu_control  in  4  operation select.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  consumer takes the result.
REQ-014 alu_out  out  WIDTH  registered result.
REQ-015 zout  out  1  registered flag, high when alu_out is 0.
REQ-016 ovf  out  1  registered signed overflow flag for ADD/SUB.
REQ-017 dz  out  1  registered divide-by-zero flag for DIVU/REMU.

Function
REQ-018 SHALL decode alu_control as follows:
- 0000 NAND, 0001 OR, 0010 ADD, 0110 SUB.
- 0111 SLT, unsigned: 1 if a<b, else 0.
- 0100 SLL: a<<shamt; result is 0 if shamt>=WIDTH.
- 0101 MOVE: result is a.
- 1000 MUL: low WIDTH bits of the unsigned product.
- 1001 MULHU: high WIDTH bits of the unsigned product.
- 1010 DIVU: unsigned quotient.
- 1011 REMU: unsigned remainder.
- Any other code: result 0, all flags 0.
REQ-019 SHALL implement an FSM with states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE.
REQ-020 SHALL accept a request when in_valid&&in_ready, capturing a, b, shamt and alu_control; input changes after acceptance SHALL be ignored.
REQ-021 Single-cycle codes (0xxx and undefined codes) SHALL go IDLE->DONE, with out_valid high on the cycle after acceptance (latency 1).
REQ-022 Iterative codes (1000-1011) SHALL go IDLE->BUSY and run a shift-add multiply or restoring divide, one bit per cycle, tracked by a WIDTH-cycle counter.
REQ-023 After BUSY the FSM SHALL go BUSY->DONE, with out_valid high WIDTH+1 cycles after acceptance.
REQ-024 In DONE, alu_out, zout, ovf, dz and out_valid SHALL hold stable until out_valid&&out_ready.
REQ-025 On out_valid&&out_ready the FSM SHALL go to IDLE and deassert out_valid next cycle; there is no same-cycle re-accept, so at most one request is in flight.
REQ-026 ovf SHALL equal the signed two's-complement overflow for ADD/SUB and SHALL be 0 for all other codes.
REQ-027 For divisor b==0: DIVU SHALL return all ones, REMU SHALL return a, and dz SHALL be 1; latency stays WIDTH+1.
REQ-028 zout SHALL be computed from the final result and registered together with alu_out.
REQ-029 While not in DONE, alu_out, zout, ovf and dz SHALL retain their last values; consumers qualify them with out_valid.

Reset
REQ-030 rst_n low SHALL immediately force the FSM to IDLE, clear the counter and internal registers, and drive alu_out=0, zout=0, ovf=0, dz=0, out_valid=0, in_ready=1.
REQ-031 Reset during BUSY or DONE SHALL abort the operation with no out_valid produced; the first acceptance is allowed on the first rising edge after rst_n deasserts.

Verification (WIDTH=32)
REQ-032 ADD a=0x7FFFFFFF, b=1 -> alu_out=0x80000000, ovf=1, zout=0, out_valid 1 cycle after acceptance.
REQ-033 MUL a=0x00010000, b=0x00010000 -> alu_out=0, zout=1, out_valid at cycle 33; MULHU with the same operands -> alu_out=1.
REQ-034 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF, dz=1; REMU 5/0 -> 5, dz=1.
REQ-035 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> outputs stable, in_ready=0, new request not accepted until 1 cycle after the handshake.
REQ-036 Assert rst_n=0 at BUSY cycle 10 of a MUL -> all outputs 0 and in_ready=1 at once, with no stale out_valid after release.
REQ-037 SLL a=1, shamt=31 -> 0x80000000; shamt=32 -> 0, zout=1; alu_control=0011 -> alu_out=0, zout=1, latency 1.
